// File: rtl/rtc_pkg.sv
// rtc_pkg: shared widths, limits and the 24h -> 12h display helper for the
// real-time clock core.
//   SEC_W/MIN_W/HR_W    : field widths of seconds, minutes, hours
//   SEC_MAX/MIN_MAX/HR_MAX : last legal value of each field
//   to_12h(hr)          : returns {pm, hr12} for a 24-hour hour value
package rtc_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

  // hr 0 shows as 12 (midnight), 13..23 fold down by 12, pm from hr >= 12
  function automatic logic [HR_W:0] to_12h(input logic [HR_W-1:0] hr);
    logic            pm;
    logic [HR_W-1:0] hr12;
    pm = (hr >= 5'd12);
    if (hr == '0) begin
      hr12 = 5'd12;
    end else if (hr > 5'd12) begin
      hr12 = hr - 5'd12;
    end else begin
      hr12 = hr;
    end
    return {pm, hr12};
  endfunction

endpackage

// File: rtl/rtc_clk_param_prescaler.sv
// rtc_prescaler: divides clk down to a one-cycle tick every CLK_FREQ_HZ
// enabled cycles.
//   clk   : system clock
//   reset : synchronous active-high reset, clears the count
//   en    : count enable; the count holds while low
//   clr   : synchronous clear back to phase 0 (used by time-set)
//   tick  : high during the cycle whose edge wraps CLK_FREQ_HZ-1 -> 0
module rtc_prescaler #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int PRESC_W     = $clog2(CLK_FREQ_HZ)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(CLK_FREQ_HZ - 1);

  logic [PRESC_W-1:0] cnt;

  // combinational so the consumer can act on the same edge as the wrap
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/rtc_clk_param.sv
// rtc_clk_param: HH:MM:SS clock core with run/pause, range-checked time set,
// 12/24-hour display and tick/rollover strobes.
//   clk, reset          : system clock, synchronous active-high reset
//   run_en              : advance time when high, hold when low
//   mode_12h            : display hours as 1..12 when high, 0..23 when low
//   set_valid, set_*    : one-cycle load of a 24-hour time
//   seconds/minutes/hours_out, pm_out : displayed time
//   sec_tick, day_tick  : pulses with each new second / midnight rollover
//   set_err             : pulse when a set carried an out-of-range field
// Optional alarm when RTC_ALARM_EN is defined:
//   alarm_set, alarm_hours, alarm_minutes : store alarm time (range checked)
//   alarm_arm           : enable alarm
//   alarm_pulse         : pulse when a tick reaches alarm_hh:alarm_mm:00
module rtc_clk_param
  import rtc_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int PRESC_W     = $clog2(CLK_FREQ_HZ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic             mode_12h,
  input  logic             set_valid,
  input  logic [SEC_W-1:0] set_seconds,
  input  logic [MIN_W-1:0] set_minutes,
  input  logic [HR_W-1:0]  set_hours,
  output logic [SEC_W-1:0] seconds_out,
  output logic [MIN_W-1:0] minutes_out,
  output logic [HR_W-1:0]  hours_out,
  output logic             pm_out,
  output logic             sec_tick,
  output logic             day_tick,
  output logic             set_err
`ifdef RTC_ALARM_EN
  ,
  input  logic             alarm_set,
  input  logic [HR_W-1:0]  alarm_hours,
  input  logic [MIN_W-1:0] alarm_minutes,
  input  logic             alarm_arm,
  output logic             alarm_pulse
`endif
);

  logic [SEC_W-1:0] sec, sec_n;
  logic [MIN_W-1:0] min, min_n;
  logic [HR_W-1:0]  hr, hr_n, hr12;
  logic             day_wrap;
  logic             tick;
  logic             set_ok;

  assign set_ok = set_valid && (set_seconds <= SEC_MAX) &&
                  (set_minutes <= MIN_MAX) && (set_hours <= HR_MAX);

  // an accepted set restarts the second from phase 0
  rtc_prescaler #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .PRESC_W    (PRESC_W)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .en   (run_en),
    .clr  (set_ok),
    .tick (tick)
  );

  always_comb begin
    sec_n    = sec + 6'd1;
    min_n    = min;
    hr_n     = hr;
    day_wrap = 1'b0;
    if (sec == SEC_MAX) begin
      sec_n = '0;
      if (min == MIN_MAX) begin
        min_n = '0;
        if (hr == HR_MAX) begin
          hr_n     = '0;
          day_wrap = 1'b1;
        end else begin
          hr_n = hr + 5'd1;
        end
      end else begin
        min_n = min + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec      <= '0;
      min      <= '0;
      hr       <= '0;
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
      if (set_ok) begin
        // set wins over a coincident wrap; that tick is dropped
        sec <= set_seconds;
        min <= set_minutes;
        hr  <= set_hours;
      end else begin
        if (set_valid) begin
          set_err <= 1'b1;
        end
        if (tick) begin
          sec      <= sec_n;
          min      <= min_n;
          hr       <= hr_n;
          sec_tick <= 1'b1;
          day_tick <= day_wrap;
        end
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic [HR_W-1:0]  alarm_hr;
  logic [MIN_W-1:0] alarm_min;

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_hr    <= '0;
      alarm_min   <= '0;
      alarm_pulse <= 1'b0;
    end else begin
      if (alarm_set && (alarm_hours <= HR_MAX) && (alarm_minutes <= MIN_MAX)) begin
        alarm_hr  <= alarm_hours;
        alarm_min <= alarm_minutes;
      end
      // only a tick can fire it, so a set landing on the alarm time is silent
      alarm_pulse <= tick && !set_ok && alarm_arm && (sec_n == '0) &&
                     (min_n == alarm_min) && (hr_n == alarm_hr);
    end
  end
`endif

  assign {pm_out, hr12} = to_12h(hr);
  assign seconds_out    = sec;
  assign minutes_out    = min;
  assign hours_out      = mode_12h ? hr12 : hr;

endmodule

// File: doc/rtc_clk_param.md
Name: rtc_clk_param

Overview:
- Parametrised successor of the seconds/minutes/hours clock core: a prescaler divides the system clock down to a 1 Hz tick, which drives a cascaded HH:MM:SS counter.
- Adds run/pause, synchronous time-set with range checking, 12/24-hour display mode, and tick/rollover strobes.
- Sits directly under the clock top level and feeds display/decoder logic.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock cycles per second; benches override it with small values (e.g. 10). Legal when >= 2.
- PRESC_W, $clog2(CLK_FREQ_HZ), prescaler counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run_en  in  1  1 = time advances; 0 = prescaler and time hold.
- mode_12h  in  1  0 = 24-hour display; 1 = 12-hour display.
- set_valid  in  1  one-cycle strobe; load the set_* values.
- set_seconds  in  6  0..59.
- set_minutes  in  6  0..59.
- set_hours  in  5  0..23, always given in 24-hour form.
- seconds_out  out  6  current seconds.
- minutes_out  out  6  current minutes.
- hours_out  out  5  0..23 in 24-hour mode; 1..12 in 12-hour mode.
- pm_out  out  1  1 when internal hour >= 12, valid in both modes.
- sec_tick  out  1  one-cycle pulse on each seconds increment.
- day_tick  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
- set_err  out  1  one-cycle pulse when a set is rejected.

Behaviour:
- Reset: prescaler=0; internal sec/min/hr=0; sec_tick, day_tick, set_err = 0.
  - Outputs after reset: hours_out = 0 in 24-hour mode, 12 in 12-hour mode; pm_out=0.
  - Reset has priority over every other input, including mid-count and mid-set.
- Prescaler: counts 0..CLK_FREQ_HZ-1 while run_en=1 and holds its value while run_en=0.
  - Edge at which it wraps from CLK_FREQ_HZ-1 to 0: seconds increments and sec_tick is registered high, so sec_tick coincides with the new value.
  - First increment lands exactly CLK_FREQ_HZ enabled cycles after reset deassertion.
- Cascade on a tick, all in the same edge:
  - sec 59 -> 0 with min+1.
  - min 59 -> 0 with hr+1.
  - hr 23 -> 0, and day_tick pulses with the 00:00:00 value.
- Set:
  - Accepted when set_valid=1 and all three fields are in range. Internal time loads on the next edge and the prescaler clears to 0; no sec_tick is produced that edge.
  - Any field out of range: nothing changes, the prescaler is untouched, and set_err pulses on the next edge.
  - Set_valid on the same cycle as a prescaler wrap: the set wins, the tick is discarded, and no sec_tick/day_tick is produced.
  - Set is honoured while run_en=0.
- Display conversion: combinational from the registered hour, zero latency on a mode_12h change.
  - 12-hour mapping: hr 0 -> 12, 1..12 -> same, 13..23 -> hr-12.
  - pm_out = (hr >= 12).
- Arithmetic: fixed widths 6/6/5; internal counters never exceed 59/59/23.

Optional Feature:
- Macro RTC_ALARM_EN.
- Defined, adds ports:
  - alarm_set (in 1): stores alarm_hours (in 5, 0..23) and alarm_minutes (in 6, 0..59); out-of-range values are rejected silently.
  - alarm_arm (in 1): gates the alarm.
  - alarm_pulse (out 1): one-cycle pulse in the same edge a tick advances the time to alarm_hh:alarm_mm:00 while alarm_arm=1.
  - A time set landing on the alarm time does not fire it.
  - Reset: alarm registers = 00:00, alarm_pulse = 0.
- Undefined: these ports and registers do not exist; the block behaves exactly as specified above.

Decomposition:
- Package rtc_pkg holds:
  - Width constants SEC_W=6, MIN_W=6, HR_W=5.
  - Limits SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
  - Function to_12h(hr) -> {pm, hr12}.
- One sub-module, rtc_prescaler: parameter CLK_FREQ_HZ; ports clk, reset, en, clr, tick.
- Cascade, set and alarm logic stay in rtc_clk_param.

Test Plan:
- All cases use CLK_FREQ_HZ=10.
- Reset release, run_en=1: first sec_tick 10 cycles after reset low, seconds_out=1; after 600 cycles, minutes_out=1 and seconds_out=0.
- Set 23:59:58 then run: two ticks later reads 00:00:00, day_tick pulses exactly on that edge, and sec_tick also pulses.
- set_valid with set_seconds=60 (or set_hours=24): set_err pulses one cycle, time and prescaler phase unchanged.
- set_valid on the wrap cycle: loaded value appears with no increment, and the next sec_tick comes 10 cycles later.
- mode_12h sweep: hr 0 -> 12/pm 0; hr 12 -> 12/pm 1; hr 13 -> 1/pm 1; hr 23 -> 11/pm 1. run_en=0 for 50 cycles: no change, and on resume the prescaler continues from its held value.
- RTC_ALARM_EN build: alarm 00:01, armed, start 00:00:58 -> alarm_pulse 20 cycles later, once; disarmed repeat -> no pulse; set directly to 00:01:00 -> no pulse.
